// File: rtl/proc_pkg.sv
// Shared processor package: memory geometry defaults, arbiter FSM state
// encoding and a helper that maps a cycle's grant to the next owner state.
package proc_pkg;

   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 8;

   // Grant vector bit positions
   localparam int PORT_CPU = 0;
   localparam int PORT_DBG = 1;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_CPU_OWN    = 2'd1,
      ST_DBG_OWN    = 2'd2,
      ST_DBG_LOCKED = 2'd3
   } arb_state_t;

   // Owner recorded after a cycle whose grant is gnt (one-hot or zero).
   // A debug grant taken with lock asserted enters the locked state.
   function automatic arb_state_t next_owner(input logic [1:0] gnt, input logic lock);
      arb_state_t ns;
      ns = ST_IDLE;
      if (gnt[PORT_CPU])      ns = ST_CPU_OWN;
      else if (gnt[PORT_DBG]) ns = lock ? ST_DBG_LOCKED : ST_DBG_OWN;
      return ns;
   endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-way alternating picker.
//   req     : requests, [0] = low port, [1] = high port
//   last_p0 : low port owned the previous access
//   lock    : high port holds priority
//   gnt     : one-hot grant (zero when no request)
// A lone requester always wins. Under contention the high port wins only
// if the low port went last or the high port holds the lock.
module arb_rr2 (
   input  logic [1:0] req,
   input  logic       last_p0,
   input  logic       lock,
   output logic [1:0] gnt
);

   logic hi_first;

   assign hi_first = last_p0 | lock;

   always_comb begin
      gnt = 2'b00;
      if (req == 2'b11) gnt = hi_first ? 2'b10 : 2'b01;
      else              gnt = req;
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter between the processor port and the debug/loader port in front of
// a single-port synchronous memory.
//   clock, reset (async, active low)
//   cpu_req/we/addr/wdata -> cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata
//   dbg_req/we/addr/wdata, dbg_lock -> dbg_gnt, dbg_rvalid, dbg_rdata
//   mem_en/we/addr/wdata -> memory command, mem_rdata <- data one cycle later
// Grants are decided combinationally in the request cycle; a 1-bit tag
// follows each read so the return lands on the port that issued it.
module mem_arbiter
   import proc_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_stall,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   input  logic              dbg_lock,
   output logic              dbg_gnt,
   output logic              dbg_rvalid,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   arb_state_t        state;
   logic              lock_hold;
   logic [1:0]        arb_gnt, gnt;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              rd_vld, rd_tag;     // rd_tag: 1 = debug issued the read
   logic [DATA_W-1:0] cpu_rdata_q, dbg_rdata_q;

   // Locked only while the lock is still requested; a dropped lock falls
   // back to idle priority in the same cycle, so the cpu can win at once.
   assign lock_hold = (state == ST_DBG_LOCKED) && dbg_lock;

   arb_rr2 u_arb (
      .req     ({dbg_req, cpu_req}),
      .last_p0 (state == ST_CPU_OWN),
      .lock    (lock_hold),
      .gnt     (arb_gnt)
   );

   // No grants while reset is held, even with requests present.
   assign gnt     = arb_gnt & {2{reset}};
   assign cpu_gnt = gnt[PORT_CPU];
   assign dbg_gnt = gnt[PORT_DBG];
   assign mem_en  = |gnt;

   // Address/data hold their last driven value between grants.
   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      if (gnt[PORT_CPU]) begin
         mem_we    = cpu_we;
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
      end else if (gnt[PORT_DBG]) begin
         mem_we    = dbg_we;
         mem_addr  = dbg_addr;
         mem_wdata = dbg_wdata;
      end
   end

   assign cpu_rvalid = rd_vld & ~rd_tag;
   assign dbg_rvalid = rd_vld &  rd_tag;
   assign cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_q;
   assign dbg_rdata  = dbg_rvalid ? mem_rdata : dbg_rdata_q;

   // Stall while waiting for a grant, and through the read-return cycle.
   assign cpu_stall  = reset & ((cpu_req & ~gnt[PORT_CPU]) | cpu_rvalid);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= ST_IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         rd_vld      <= 1'b0;
         rd_tag      <= 1'b0;
         cpu_rdata_q <= '0;
         dbg_rdata_q <= '0;
      end else begin
         state <= lock_hold ? ST_DBG_LOCKED : next_owner(gnt, dbg_lock);
         if (mem_en) begin
            addr_q  <= mem_addr;
            wdata_q <= mem_wdata;
         end
         rd_vld <= mem_en & ~mem_we;
         rd_tag <= gnt[PORT_DBG];
         if (cpu_rvalid) cpu_rdata_q <= mem_rdata;
         if (dbg_rvalid) dbg_rdata_q <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       cpu_req = 0, cpu_we = 0, dbg_req = 0, dbg_we = 0, dbg_lock = 0;
   logic [7:0] cpu_addr = 0, cpu_wdata = 0, dbg_addr = 0, dbg_wdata = 0;
   logic       cpu_gnt, cpu_stall, cpu_rvalid, dbg_gnt, dbg_rvalid;
   logic [7:0] cpu_rdata, dbg_rdata;
   logic       mem_en, mem_we;
   logic [7:0] mem_addr, mem_wdata;
   logic [7:0] mem_rdata = 8'h00;

   int n_chk = 0;
   int n_err = 0;

   mem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
      .clock(clock), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 clock = ~clock;

   // Environment memory: synchronous single port.
   logic [7:0] tb_mem [256];
   always @(posedge clock)
      if (mem_en) begin
         if (mem_we) tb_mem[mem_addr] <= mem_wdata;
         else        mem_rdata <= tb_mem[mem_addr];
      end

   // Reference model: who went last (0 none, 1 cpu, 2 dbg), lock held,
   // pending read owner (0 none, 1 cpu, 2 dbg) and its data.
   logic [7:0] ref_mem [256];
   bit         m_locked;
   int         m_last, m_pend;
   logic [7:0] m_pdata, m_crd, m_drd, m_addr, m_wdata;

   logic       o_cgnt, o_dgnt, o_crv, o_drv, o_stall;
   logic [7:0] o_crd, o_drd;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_locked = 0; m_last = 0; m_pend = 0;
      m_crd = 0; m_drd = 0; m_addr = 0; m_wdata = 0;
   endtask

   task automatic cyc(input logic creq, input logic cwe, input logic [7:0] ca, input logic [7:0] cd,
                      input logic dreq, input logic dwe, input logic [7:0] da, input logic [7:0] dd,
                      input logic dlk);
      bit gc, gd, we;
      logic [7:0] a, d;
      @(negedge clock);
      cpu_req = creq; cpu_we = cwe; cpu_addr = ca; cpu_wdata = cd;
      dbg_req = dreq; dbg_we = dwe; dbg_addr = da; dbg_wdata = dd; dbg_lock = dlk;
      #1;
      if (creq && dreq) begin
         gd = (m_locked && dlk) || (!m_locked && m_last == 1);
         gc = !gd;
      end else begin
         gc = creq; gd = dreq;
      end
      we = gc ? cwe : (gd ? dwe : 1'b0);
      a  = gc ? ca  : (gd ? da  : m_addr);
      d  = gc ? cd  : (gd ? dd  : m_wdata);
      chk("cpu_gnt",    cpu_gnt,    gc);
      chk("dbg_gnt",    dbg_gnt,    gd);
      chk("mem_en",     mem_en,     gc | gd);
      chk("mem_we",     mem_we,     we);
      chk("mem_addr",   mem_addr,   a);
      chk("mem_wdata",  mem_wdata,  d);
      chk("cpu_rvalid", cpu_rvalid, m_pend == 1);
      chk("dbg_rvalid", dbg_rvalid, m_pend == 2);
      chk("cpu_rdata",  cpu_rdata,  (m_pend == 1) ? m_pdata : m_crd);
      chk("dbg_rdata",  dbg_rdata,  (m_pend == 2) ? m_pdata : m_drd);
      chk("cpu_stall",  cpu_stall,  (creq && !gc) || (m_pend == 1));
      o_cgnt = cpu_gnt; o_dgnt = dbg_gnt; o_crv = cpu_rvalid; o_drv = dbg_rvalid;
      o_crd = cpu_rdata; o_drd = dbg_rdata; o_stall = cpu_stall;
      // advance model to the next cycle
      if (m_pend == 1) m_crd = m_pdata;
      if (m_pend == 2) m_drd = m_pdata;
      m_pend = 0;
      if (gc || gd) begin
         m_addr = a; m_wdata = d;
         if (we) ref_mem[a] = d;
         else begin m_pend = gc ? 1 : 2; m_pdata = ref_mem[a]; end
      end
      if (!(m_locked && dlk)) begin
         m_locked = gd && dlk;
         m_last   = gc ? 1 : (gd ? 2 : 0);
      end
   endtask

   task automatic idle();
      cyc(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
   endtask

   initial begin
      bit lk;
      for (int i = 0; i < 256; i++) begin
         tb_mem[i]  = 8'(i * 13 + 7);
         ref_mem[i] = 8'(i * 13 + 7);
      end
      tb_mem[8'h10] = 8'hA5; ref_mem[8'h10] = 8'hA5;
      tb_mem[8'h20] = 8'h11; ref_mem[8'h20] = 8'h11;
      tb_mem[8'h21] = 8'h22; ref_mem[8'h21] = 8'h22;
      model_reset();

      // reset state
      #3;
      chk("rst_cpu_gnt", cpu_gnt, 0);
      chk("rst_mem_en",  mem_en,  0);
      chk("rst_addr",    mem_addr, 0);
      chk("rst_rdata",   cpu_rdata, 0);
      @(negedge clock);
      reset = 1'b1;

      // single cpu read of 0x10
      cyc(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 0);
      chk("r036_gnt", o_cgnt, 1);
      chk("r036_stall_n", o_stall, 0);
      idle();
      chk("r036_rvalid", o_crv, 1);
      chk("r036_rdata", o_crd, 8'hA5);
      chk("r036_stall_wait", o_stall, 1);
      idle();
      chk("r036_stall_end", o_stall, 0);

      // contention from idle: strict alternation
      for (int i = 0; i < 6; i++) begin
         cyc(1, 1, 8'(8'h40 + i), 8'(i), 1, 1, 8'(8'h48 + i), 8'(i + 8), 0);
         chk("r037_cgnt", o_cgnt, (i % 2) == 0);
         chk("r037_stall", o_stall, (i % 2) == 1);
      end

      // locked debug burst against a waiting cpu read
      cyc(1, 1, 8'h50, 8'h77, 0, 0, 8'h00, 8'h00, 0);
      for (int i = 0; i < 4; i++) begin
         cyc(1, 0, 8'h02, 8'h00, 1, 1, 8'(i), 8'(i), 1);
         chk("r038_dgnt", o_dgnt, 1);
         chk("r038_stall", o_stall, 1);
      end
      cyc(1, 0, 8'h02, 8'h00, 1, 1, 8'h05, 8'h55, 0);
      chk("r038_unlock_cgnt", o_cgnt, 1);
      idle();
      chk("r038_rdata", o_crd, 8'h02);

      // alternating reads return on their own ports
      cyc(1, 0, 8'h20, 8'h00, 0, 0, 8'h00, 8'h00, 0);
      cyc(0, 0, 8'h00, 8'h00, 1, 0, 8'h21, 8'h00, 0);
      chk("r039_crv", o_crv, 1);
      chk("r039_crd", o_crd, 8'h11);
      chk("r039_drv_n", o_drv, 0);
      idle();
      chk("r039_drv", o_drv, 1);
      chk("r039_drd", o_drd, 8'h22);
      chk("r039_crv_n", o_crv, 0);

      // reset lands on a cpu read grant
      cyc(1, 0, 8'h30, 8'h00, 0, 0, 8'h00, 8'h00, 0);
      #1 reset = 1'b0;
      #1;
      chk("r040_cgnt",   cpu_gnt, 0);
      chk("r040_dgnt",   dbg_gnt, 0);
      chk("r040_en",     mem_en, 0);
      chk("r040_we",     mem_we, 0);
      chk("r040_stall",  cpu_stall, 0);
      chk("r040_addr",   mem_addr, 0);
      chk("r040_wdata",  mem_wdata, 0);
      chk("r040_crd",    cpu_rdata, 0);
      chk("r040_drd",    dbg_rdata, 0);
      chk("r040_crv",    cpu_rvalid, 0);
      cpu_req = 0;
      @(negedge clock);
      reset = 1'b1;
      model_reset();
      cyc(1, 0, 8'h31, 8'h00, 1, 0, 8'h32, 8'h00, 0);
      chk("r040_no_rvalid", o_crv, 0);
      chk("r040_idle_cpu_wins", o_cgnt, 1);

      // randomized traffic
      lk = 0;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 7) == 0) lk = !lk;
         cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), lk);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8: memory address width.
REQ-002 Parameter DATA_W, default 8: memory data width.
REQ-003 clock  in  1  single clock for the block; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous active-low reset.
REQ-005 cpu_req  in  1  processor access request (FSM MemRead|MemWrite).
REQ-006 cpu_we  in  1  processor write strobe, valid with cpu_req.
REQ-007 cpu_addr  in  ADDR_W  processor address.
REQ-008 cpu_wdata  in  DATA_W  processor write data.
REQ-009 cpu_gnt  out  1  processor access issued this cycle.
REQ-010 cpu_stall  out  1  processor must hold its FSM state and counter.
REQ-011 cpu_rvalid / cpu_rdata  out  1 / DATA_W  processor read return.
REQ-012 dbg_req, dbg_we, dbg_addr, dbg_wdata  in  1, 1, ADDR_W, DATA_W  debug/loader port request.
REQ-013 dbg_lock  in  1  debug asks to hold ownership for a burst (program load).
REQ-014 dbg_gnt, dbg_rvalid, dbg_rdata  out  1, 1, DATA_W  debug grant and read return.
REQ-015 mem_en, mem_we, mem_addr, mem_wdata  out  1, 1, ADDR_W, DATA_W  single-port synchronous memory command.
REQ-016 mem_rdata  in  DATA_W  memory read data, valid one cycle after a read command.

Function
REQ-017 Arbitration SHALL be combinational in the request cycle: at most one grant per cycle, and mem_* SHALL carry the granted requester's signals with mem_en=1 in that cycle.
REQ-018 With no grant, mem_en=0, mem_we=0, and mem_addr/mem_wdata SHALL hold their last driven values.
REQ-019 FSM states: IDLE, CPU_OWN, DBG_OWN, DBG_LOCKED; the state records the last owner and updates every cycle.
REQ-020 When only one port requests, that port SHALL be granted regardless of state.
REQ-021 When both request in IDLE or DBG_OWN, cpu SHALL be granted; in CPU_OWN, dbg SHALL be granted (strict alternation).
REQ-022 Transition to DBG_LOCKED SHALL occur when dbg is granted with dbg_lock=1; in DBG_LOCKED, dbg wins every contention while dbg_lock=1.
REQ-023 DBG_LOCKED SHALL exit to IDLE on the first cycle with dbg_lock=0; cpu_req is then eligible in that same cycle.
REQ-024 No requests in any non-locked state SHALL return the FSM to IDLE; DBG_LOCKED SHALL persist with no requests while dbg_lock=1.
REQ-025 cpu_stall SHALL equal cpu_req & ~cpu_gnt, plus one cycle after a cpu read grant until cpu_rvalid.
REQ-026 Read latency: a read granted in cycle N SHALL assert the same port's rvalid in cycle N+1 for exactly one cycle, with rdata=mem_rdata.
REQ-027 Writes complete in the grant cycle; no rvalid SHALL be produced for a write.
REQ-028 rdata outputs SHALL hold their last returned value when rvalid=0.
REQ-029 Back-to-back reads by alternating ports SHALL each return rvalid on the correct port; the return tag is a 1-bit pipeline register.
REQ-030 Requests with req=0 SHALL be ignored regardless of we/addr/wdata values.

Reset
REQ-031 During reset: FSM=IDLE, all gnt/rvalid/mem_en/mem_we/cpu_stall=0, rdata/mem_addr/mem_wdata=0.
REQ-032 A read granted in the cycle reset asserts SHALL produce no rvalid; the in-flight tag is discarded.
REQ-033 After reset release, the first edge SHALL evaluate requests normally from IDLE.

Structure
REQ-034 The FSM state encoding and ADDR_W/DATA_W defaults SHALL live in the shared processor package (proc_pkg).
REQ-035 The two-way alternating picker SHALL be one sub-module, arb_rr2 (inputs: two requests, last owner, lock; output: one-hot grant).

Verification
REQ-036 cpu read only, addr 0x10, mem holds 0xA5 -> cpu_gnt in cycle N, cpu_rvalid=1 with cpu_rdata=0xA5 in N+1, cpu_stall=0 in N and 1 in no cycle other than N+1 wait.
REQ-037 Both ports request continuously for 6 cycles from IDLE -> grants cpu,dbg,cpu,dbg,cpu,dbg; cpu_stall=1 on dbg cycles.
REQ-038 dbg writes 0x00..0x03 to addr 0x00..0x03 with dbg_lock=1 while cpu_req=1 -> four consecutive dbg_gnt, cpu_stall=1 throughout; lock drop -> cpu_gnt same cycle.
REQ-039 Alternating reads cpu@0x20 (0x11), dbg@0x21 (0x22) -> cpu_rvalid/0x11 then dbg_rvalid/0x22, never both in one cycle.
REQ-040 reset asserted in cycle of cpu read grant -> no cpu_rvalid, all outputs 0, FSM IDLE after release.
